// File: rtl/sbox_layer_seq.sv
// -----------------------------------------------------------------------------
// sbox_layer_seq
//
// Sequencer wrapped around the 2-share threshold S-box. A pass takes the full
// 2-share state, presents one nibble pair (plus 4 guard bits) per cycle to the
// S-box, collects the S-box results SBOX_LAT cycles later and reassembles the
// substituted 2-share state. The two shares travel through separate shift
// registers end to end and are never combined.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   start                  request a pass; only looked at in IDLE
//   share0_in, share1_in   input shares, nibble k = bits [4k+3:4k]
//   guards_in              fresh guard bits, one nibble per feed cycle
//   seed                   PRNG seed (internal PRNG build only)
//   sbox_in0/1, sbox_guards  registered drive to the S-box, 0 outside FEED
//   sbox_out0/1            S-box result shares
//   share0_out, share1_out substituted shares, updated only on DONE
//   busy                   high from first FEED cycle to last DRAIN cycle
//   done                   one-cycle pulse, outputs valid from this cycle on
//
// Handshake: start is a level sampled at a clock edge while IDLE; there is no
// ready/queueing, so a start seen while busy or in DONE is dropped. done is a
// single-cycle pulse and share*_out then hold until the next done.
//
// Build option: define SBOX_INTERNAL_PRNG_EN to source the guard bits from an
// internal 31-bit LFSR (x^31+x^28+1) seeded from seed instead of guards_in.
// -----------------------------------------------------------------------------
module sbox_layer_seq #(
    parameter int NIBBLES  = 32,
    parameter int SBOX_LAT = 2,
    parameter int CW       = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] share0_in,
    input  logic [4*NIBBLES-1:0] share1_in,
    input  logic [3:0]           guards_in,
    input  logic [30:0]          seed,
    output logic [3:0]           sbox_in0,
    output logic [3:0]           sbox_in1,
    output logic [3:0]           sbox_guards,
    input  logic [3:0]           sbox_out0,
    input  logic [3:0]           sbox_out1,
    output logic [4*NIBBLES-1:0] share0_out,
    output logic [4*NIBBLES-1:0] share1_out,
    output logic                 busy,
    output logic                 done
);

    localparam int W = 4 * NIBBLES;
    localparam logic [CW-1:0] LAST_FEED = CW'(NIBBLES - 1);
    localparam logic [CW-1:0] FIRST_CAP = CW'(SBOX_LAT);
    localparam logic [CW-1:0] LAST_CAP  = CW'(NIBBLES + SBOX_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_isr0;
    logic [W-1:0]    r_isr1;
    logic [W-1:0]    r_osr0;
    logic [W-1:0]    r_osr1;
    logic [CW-1:0]   r_feed_cnt;
    // Counts cycles since feed cycle 0; drives both capture start and end.
    logic [CW-1:0]   r_cap_cnt;

    logic            w_last_feed;
    logic            w_cap_en;
    logic            w_last_cap;
    logic [W-1:0]    w_osr0_next;
    logic [W-1:0]    w_osr1_next;
    logic [3:0]      w_guard_load;
    logic [3:0]      w_guard_next;

    assign w_last_feed = (r_feed_cnt == LAST_FEED);
    assign w_last_cap  = (r_cap_cnt == LAST_CAP);
    assign w_cap_en    = ((r_state == S_FEED) || (r_state == S_DRAIN)) &&
                         (r_cap_cnt >= FIRST_CAP);
    // Captures enter at the MSB so nibble 0 ends up at the bottom.
    assign w_osr0_next = {sbox_out0, r_osr0[W-1:4]};
    assign w_osr1_next = {sbox_out1, r_osr1[W-1:4]};

`ifdef SBOX_INTERNAL_PRNG_EN
    logic [30:0] r_lfsr;
    logic [30:0] w_seed_nz;
    logic        w_unused_guards;

    assign w_unused_guards = ^guards_in;
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    assign w_seed_nz       = (seed == 31'd0) ? 31'd1 : seed;

    function automatic logic [30:0] lfsr_step4(input logic [30:0] s);
        logic [30:0] v;
        v = s;
        for (int i = 0; i < 4; i++) begin
            v = {v[29:0], v[30] ^ v[27]};
        end
        return v;
    endfunction

    // Feed cycle 0 uses the seed itself; every later feed cycle uses the
    // state 4 steps further on.
    assign w_guard_load = w_seed_nz[3:0];
    assign w_guard_next = r_lfsr[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 31'd1;
        end else if ((r_state == S_IDLE) && start) begin
            r_lfsr <= lfsr_step4(w_seed_nz);
        end else if ((r_state == S_FEED) && !w_last_feed) begin
            r_lfsr <= lfsr_step4(r_lfsr);
        end
    end
`else
    logic w_unused_seed;

    assign w_unused_seed = ^seed;
    assign w_guard_load  = guards_in;
    assign w_guard_next  = guards_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_isr0      <= '0;
            r_isr1      <= '0;
            r_osr0      <= '0;
            r_osr1      <= '0;
            r_feed_cnt  <= '0;
            r_cap_cnt   <= '0;
            sbox_in0    <= '0;
            sbox_in1    <= '0;
            sbox_guards <= '0;
            share0_out  <= '0;
            share1_out  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Nibble 0 goes straight to the S-box register; the
                        // shift registers keep the rest.
                        r_isr0      <= share0_in >> 4;
                        r_isr1      <= share1_in >> 4;
                        sbox_in0    <= share0_in[3:0];
                        sbox_in1    <= share1_in[3:0];
                        sbox_guards <= w_guard_load;
                        r_feed_cnt  <= '0;
                        r_cap_cnt   <= '0;
                        busy        <= 1'b1;
                        r_state     <= S_FEED;
                    end
                end
                S_FEED: begin
                    r_feed_cnt <= r_feed_cnt + CW'(1);
                    r_cap_cnt  <= r_cap_cnt + CW'(1);
                    if (w_last_feed) begin
                        sbox_in0    <= '0;
                        sbox_in1    <= '0;
                        sbox_guards <= '0;
                        r_state     <= S_DRAIN;
                    end else begin
                        sbox_in0    <= r_isr0[3:0];
                        sbox_in1    <= r_isr1[3:0];
                        sbox_guards <= w_guard_next;
                        r_isr0      <= r_isr0 >> 4;
                        r_isr1      <= r_isr1 >> 4;
                    end
                end
                S_DRAIN: begin
                    r_cap_cnt <= r_cap_cnt + CW'(1);
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Capture runs across FEED and DRAIN; the final capture also
            // publishes the result and ends the pass (this overrides the
            // FEED->DRAIN move when SBOX_LAT is 0).
            if (w_cap_en) begin
                r_osr0 <= w_osr0_next;
                r_osr1 <= w_osr1_next;
                if (w_last_cap) begin
                    share0_out <= w_osr0_next;
                    share1_out <= w_osr1_next;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    r_state    <= S_DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_sbox_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_sbox_layer_seq
//
// Directed bench for sbox_layer_seq with a behavioural 2-share S-box
// (2-cycle latency, out = {S(in0^in1)^r, r} with r = guard nibble).
// Expected states are hand-computed per-nibble uBlock S-box lookups.
// -----------------------------------------------------------------------------
module tb_sbox_layer_seq;

    localparam int NIB = 32;
    localparam int W   = 4 * NIB;

    localparam logic [W-1:0] X_IN  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [W-1:0] X_EXP = 128'h749CBAD8FE160325_523061EF8DABC947;
    localparam logic [W-1:0] Y_IN  = 128'hFEDCBA9876543210_0123456789ABCDEF;
    localparam logic [W-1:0] Y_EXP = 128'h523061EF8DABC947_749CBAD8FE160325;
    localparam logic [W-1:0] MASK  = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    localparam logic [W-1:0] ALL_A = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
    localparam logic [W-1:0] ALL_3 = 128'h33333333_33333333_33333333_33333333;
    localparam logic [W-1:0] ALL_7 = 128'h77777777_77777777_77777777_77777777;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   share0_in;
    logic [W-1:0]   share1_in;
    logic [3:0]     guards_in;
    logic [30:0]    seed;
    logic [3:0]     sbox_in0;
    logic [3:0]     sbox_in1;
    logic [3:0]     sbox_guards;
    logic [3:0]     sbox_out0;
    logic [3:0]     sbox_out1;
    logic [W-1:0]   share0_out;
    logic [W-1:0]   share1_out;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    sbox_layer_seq #(.NIBBLES(NIB), .SBOX_LAT(2), .CW(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .share0_in   (share0_in),
        .share1_in   (share1_in),
        .guards_in   (guards_in),
        .seed        (seed),
        .sbox_in0    (sbox_in0),
        .sbox_in1    (sbox_in1),
        .sbox_guards (sbox_guards),
        .sbox_out0   (sbox_out0),
        .sbox_out1   (sbox_out1),
        .share0_out  (share0_out),
        .share1_out  (share1_out),
        .busy        (busy),
        .done        (done)
    );

    // ---------------- S-box model ----------------
    function automatic logic [3:0] s_lut(input logic [3:0] x);
        case (x)
            4'h0: return 4'h7;  4'h1: return 4'h4;  4'h2: return 4'h9;  4'h3: return 4'hC;
            4'h4: return 4'hB;  4'h5: return 4'hA;  4'h6: return 4'hD;  4'h7: return 4'h8;
            4'h8: return 4'hF;  4'h9: return 4'hE;  4'hA: return 4'h1;  4'hB: return 4'h6;
            4'hC: return 4'h0;  4'hD: return 4'h3;  4'hE: return 4'h2;  default: return 4'h5;
        endcase
    endfunction

    logic [3:0] m_f0 = '0;
    logic [3:0] m_f1 = '0;
    logic [3:0] m_g0 = '0;
    logic [3:0] m_g1 = '0;

    always @(posedge clk) begin
        m_f0 <= s_lut(sbox_in0 ^ sbox_in1) ^ sbox_guards;
        m_f1 <= sbox_guards;
        m_g0 <= m_f0;
        m_g1 <= m_f1;
    end

    assign sbox_out0 = m_g0;
    assign sbox_out1 = m_g1;

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           busy_cnt = 0;
    int           unstable = 0;
    int           start_at[$];
    int           done_q[$];
    logic [W-1:0] cap0_q[$];
    logic [W-1:0] cap1_q[$];
    logic [W-1:0] hold0 = '0;
    logic [W-1:0] hold1 = '0;
    logic         busy_at [0:127];
    logic [3:0]   sin0_at [0:127];
    logic [3:0]   sin1_at [0:127];
    logic [3:0]   sg_at   [0:127];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dq(input int i);
        return (i < done_q.size()) ? done_q[i] : -1;
    endfunction

    function automatic logic [W-1:0] c0(input int i);
        return (i < cap0_q.size()) ? cap0_q[i] : '1;
    endfunction

    function automatic logic [W-1:0] c1(input int i);
        return (i < cap1_q.size()) ? cap1_q[i] : '1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic begin_scenario();
        start_at.delete();
        done_q.delete();
        cap0_q.delete();
        cap1_q.delete();
        busy_cnt = 0;
        unstable = 0;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    // Steps cycle by cycle up to last_cyc, driving start from start_at and
    // logging outputs sampled 1 time unit after each rising edge.
    task automatic run_until(input int last_cyc);
        while (cyc < last_cyc) begin
            start = 1'b0;
            foreach (start_at[i]) if (start_at[i] == cyc) start = 1'b1;
            if (cyc < 128) begin
                busy_at[cyc] = busy;
                sin0_at[cyc] = sbox_in0;
                sin1_at[cyc] = sbox_in1;
                sg_at[cyc]   = sbox_guards;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_q.push_back(cyc);
                cap0_q.push_back(share0_out);
                cap1_q.push_back(share1_out);
                hold0 = share0_out;
                hold1 = share1_out;
            end else if (share0_out !== hold0 || share1_out !== hold1) begin
                unstable++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        share0_in = '0;
        share1_in = '0;
        guards_in = '0;
        seed      = '0;
        #2 rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_share0_out", share0_out, '0);
        chk("rst_share1_out", share1_out, '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_sbox_in0", W'(sbox_in0), '0);
        chk("rst_sbox_in1", W'(sbox_in1), '0);
        chk("rst_sbox_guards", W'(sbox_guards), '0);
        rst_n = 1'b1;

        // Pass 1 (start in 0, ignored pulses in 5 and 35), pass 2 from 36.
        begin_scenario();
        share0_in = X_IN;
        share1_in = '0;
        guards_in = 4'hA;
        start_at  = '{0, 5, 35, 36};
        run_until(36);
        share0_in = Y_IN ^ MASK;
        share1_in = MASK;
        guards_in = 4'h3;
        run_until(80);

        chk("done_count", W'(done_q.size()), W'(2));
        chk("done_cycle_1", W'(dq(0)), W'(35));
        chk("done_cycle_2", W'(dq(1)), W'(71));
        chk("busy_cycles", W'(busy_cnt), W'(68));
        chk("busy_c1", W'(busy_at[1]), W'(1));
        chk("busy_c34", W'(busy_at[34]), W'(1));
        chk("busy_c35", W'(busy_at[35]), W'(0));
        chk("busy_c36", W'(busy_at[36]), W'(0));
        chk("busy_c37", W'(busy_at[37]), W'(1));
        chk("outputs_stable", W'(unstable), '0);
        chk("feed_in0_k1", W'(sin0_at[2]), W'(4'h1));
        chk("feed_in0_k16", W'(sin0_at[17]), W'(4'hF));
        chk("feed_in1_k16", W'(sin1_at[17]), '0);
        chk("drain_in0", W'(sin0_at[33]), '0);
        chk("drain_guards", W'(sg_at[33]), '0);
        chk("pass2_in0_k0", W'(sin0_at[37]), W'(4'hA));
        chk("pass2_in1_k0", W'(sin1_at[37]), W'(4'h5));
        chk("pass1_unmasked", c0(0) ^ c1(0), X_EXP);
        chk("pass2_unmasked", c0(1) ^ c1(1), Y_EXP);
`ifdef SBOX_INTERNAL_PRNG_EN
        chk("prng_guard_k0", W'(sg_at[1]), W'(4'h1));
        chk("prng_guard_k1", W'(sg_at[2]), W'(4'h0));
`else
        chk("feed_guards_k1", W'(sg_at[2]), W'(4'hA));
        chk("pass2_guards_k0", W'(sg_at[37]), W'(4'h3));
        chk("pass1_share1", c1(0), ALL_A);
        chk("pass2_share1", c1(1), ALL_3);
`endif

        // Reset asserted in cycle 20 of a pass.
        begin_scenario();
        start_at = '{0};
        run_until(20);
        chk("pre_reset_no_done", W'(done_q.size()), '0);
        rst_n = 1'b0;
        #1;
        chk("midrst_share0_out", share0_out, '0);
        chk("midrst_share1_out", share1_out, '0);
        chk("midrst_busy", W'(busy), '0);
        chk("midrst_sbox_in0", W'(sbox_in0), '0);
        chk("midrst_sbox_guards", W'(sbox_guards), '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold0 = '0;
        hold1 = '0;
        begin_scenario();
        run_until(40);
        chk("aborted_no_done", W'(done_q.size()), '0);
        chk("aborted_no_busy", W'(busy_cnt), '0);
        chk("aborted_stable", W'(unstable), '0);

        // Fresh pass after the abort: all-zero shares give S(0)=7 everywhere.
        begin_scenario();
        share0_in = '0;
        share1_in = '0;
        guards_in = 4'h0;
        start_at  = '{0};
        run_until(40);
        chk("fresh_done_count", W'(done_q.size()), W'(1));
        chk("fresh_done_cycle", W'(dq(0)), W'(35));
        chk("fresh_busy_cycles", W'(busy_cnt), W'(34));
        chk("fresh_unmasked", c0(0) ^ c1(0), ALL_7);
`ifndef SBOX_INTERNAL_PRNG_EN
        chk("fresh_share0", c0(0), ALL_7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sbox_layer_seq.md
Name: sbox_layer_seq

Overview:
- Sequencer sitting directly upstream and downstream of the 2-share threshold S-box.
- Takes the full 2-share uBlock state and feeds one nibble pair per cycle, with 4 guard bits, into the shared S-box.
- Collects the S-box outputs after the S-box pipeline latency and reassembles the substituted 2-share state.
- Pulses done when the whole S-box layer is finished; the round datapath consumes the result.

Parameters:
- NIBBLES, 32: nibbles per share (32 gives a 128-bit state).
- SBOX_LAT, 2: S-box input-to-output latency in cycles (F register, then G register).
- CW, 6: width of the feed and capture counters; must satisfy 2^CW > NIBBLES+SBOX_LAT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request one S-box layer pass; sampled only in IDLE.
- share0_in  in  4*NIBBLES  state share 0; nibble k is bits [4k+3:4k].
- share1_in  in  4*NIBBLES  state share 1.
- guards_in  in  4  fresh guard bits, consumed once per feed cycle.
- seed  in  31  PRNG seed; used only with the optional feature.
- sbox_in0  out  4  to S-box share-0 input (d0c0b0a0).
- sbox_in1  out  4  to S-box share-1 input (d1c1b1a1).
- sbox_guards  out  4  to S-box guards.
- sbox_out0  in  4  from S-box share-0 output (h0g0f0e0).
- sbox_out1  in  4  from S-box share-1 output (h1g1f1e1).
- share0_out  out  4*NIBBLES  substituted share 0.
- share1_out  out  4*NIBBLES  substituted share 1.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse; share outputs are valid from this cycle on.

Behaviour:
- Reset (rst_n low, asynchronous): state goes to IDLE and all of the following clear to 0: counters, input shift registers, output shift registers, share0_out, share1_out, busy, done, sbox_in0, sbox_in1, sbox_guards.
- Reset asserted mid-pass aborts the pass; no done is produced.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 at a clock edge loads share0_in and share1_in into the input shift registers, clears both counters, and moves to FEED.
  - start=0 stays in IDLE.
- FEED: lasts exactly NIBBLES cycles. In feed cycle k (k = 0..NIBBLES-1):
  - sbox_in0/sbox_in1 = nibble k of each share, taken from the LSB nibble of each shift register, which shifts right by 4 every cycle.
  - sbox_guards = guards_in.
  - After the last feed, move to DRAIN.
- Outside FEED, sbox_in0, sbox_in1 and sbox_guards are driven to 0.
- Capture:
  - The outputs for nibble k are captured at the end of cycle k+SBOX_LAT, counted from feed cycle 0.
  - Each capture shifts {sbox_out1, sbox_out0} into the MSB nibble of each output shift register.
  - After NIBBLES captures, nibble k sits at bits [4k+3:4k].
- DRAIN: lasts SBOX_LAT cycles and completes the remaining captures, then moves to DONE.
- DONE: one cycle.
  - done=1; share0_out and share1_out show the captured state.
  - Next state is IDLE.
- Timing: start sampled at the end of cycle 0 gives done high in cycle NIBBLES+SBOX_LAT+1. With the defaults, done is in cycle 35.
- busy=1 from the first FEED cycle through the last DRAIN cycle; busy=0 in DONE and IDLE.
- start is ignored while busy or in DONE; no queuing.
- start held high through DONE launches a new pass from IDLE on the next sampled edge.
- share0_out and share1_out hold their value until the next DONE; they are never updated with partial results.
- Shares are never recombined. No logic XORs share0 with share1, and no register holds both shares of the same nibble in one combinational cone.

Optional Feature:
- Macro: SBOX_INTERNAL_PRNG_EN.
- Defined:
  - guards_in is ignored.
  - sbox_guards is driven from the low 4 bits of an internal 31-bit Fibonacci LFSR, polynomial x^31+x^28+1.
  - The LFSR loads seed on the IDLE->FEED transition; an all-zero seed is forced to 1.
  - The LFSR advances 4 steps per FEED cycle only; it resets to 1.
- Undefined: no LFSR is instantiated, the seed port is unused, and sbox_guards=guards_in during FEED.

Test Plan:
- Latency with an ideal S-box model (out = uBlock S(in0^in1) split as {S^r, r}), NIBBLES=32, start in cycle 0 -> done exactly in cycle 35, busy high in cycles 1..34, done width 1.
- Both shares 0 with the real shared S-box -> share0_out^share1_out = 128'h7777...7, since uBlock S(0)=7.
- share0_in = 128'h0123456789ABCDEF_FEDCBA9876543210 with a random share1_in, real shared S-box -> the unmasked output matches a per-nibble lookup in the table {7,4,9,C,B,A,D,8,F,E,1,6,0,3,2,5}, and nibble order is preserved.
- start pulsed again in cycles 5 and 35 -> the pulse in cycle 5 is ignored; the pass started at cycle 36 yields done in cycle 71 with the previous outputs stable until then.
- rst_n low in cycle 20 mid-FEED -> all outputs read 0 immediately; no done appears; a fresh start afterwards completes normally.
- With SBOX_INTERNAL_PRNG_EN, seed=0 -> the LFSR loads 1, sbox_guards is non-constant across the 32 feed cycles, and the unmasked results are identical to the guards_in build.
